// File: rtl/opc5_mem_pkg.sv
// Shared constants for the OPC5 memory responder.
// Covers the I/O register offsets and the STATUS bit positions.
package opc5_mem_pkg;

    typedef enum logic [1:0] {
        IO_STATUS = 2'd0,
        IO_TXDATA = 2'd1,
        IO_RXDATA = 2'd2,
        IO_CYCLES = 2'd3
    } io_reg_e;

    localparam int ST_TXFULL = 0;
    localparam int ST_RXNE   = 1;
    localparam int ST_TXOVF  = 2;

endpackage

// File: rtl/opc5_byte_fifo.sv
// Byte-wide FIFO with wrapping pointers that carry one extra bit.
// The parent gates push and pop so that the FIFO never overflows or underflows.
module opc5_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wrPtr;
    logic [AW:0] r_rdPtr;
    logic [7:0]  r_mem [DEPTH];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (push) r_wrPtr <= r_wrPtr + (AW+1)'(1);
            if (pop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
        end
    end

    // When the FIFO is full, a push with a pop overwrites the slot being popped. The old byte is read before the edge.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wrPtr[AW-1:0]] <= din;
    end

    assign empty = (r_wrPtr == r_rdPtr);
    assign full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign dout  = empty ? 8'h00 : r_mem[r_rdPtr[AW-1:0]];

endmodule

// File: rtl/opc5_mem_responder.sv
// Memory side of the OPC5 bus. It contains a word RAM with combinational read,
// plus a 4-word I/O window holding TX/RX byte FIFOs and a cycle counter.
module opc5_mem_responder
    import opc5_mem_pkg::*;
#(
    parameter int          ADDR_W     = 10,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] IO_BASE    = 16'hFFF0
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [15:0] address,
    input  logic [15:0] dataout,
    input  logic        rnw,
    output logic [15:0] datain,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    logic [15:0] r_ram [2**ADDR_W];
    logic [15:0] r_cycles;
    logic        r_txOverflow;

    logic [15:0] w_ioDiff;
    logic        w_isIo;
    io_reg_e     w_ioReg;
    logic        w_ioWrite;
    logic        w_ioRead;

    logic        w_txFull, w_txEmpty, w_txWrite, w_txPush, w_txPop, w_txDrop;
    logic        w_rxFull, w_rxEmpty, w_rxPush, w_rxPop;
    logic [7:0]  w_rxDout;
    logic [15:0] w_readData;

    // Taking the offset from the base keeps the decode correct even when IO_BASE sits near the top of memory.
    assign w_ioDiff  = address - IO_BASE;
    assign w_isIo    = (w_ioDiff[15:2] == 14'd0);
    assign w_ioReg   = io_reg_e'(w_ioDiff[1:0]);
    assign w_ioWrite = w_isIo && !rnw;
    assign w_ioRead  = w_isIo && rnw;

    assign w_txPop   = tx_valid && tx_ready;
    assign w_txWrite = w_ioWrite && (w_ioReg == IO_TXDATA);
    assign w_txPush  = w_txWrite && (!w_txFull || w_txPop);
    assign w_txDrop  = w_txWrite && w_txFull && !w_txPop;
    assign tx_valid  = !w_txEmpty;

    assign w_rxPush  = rx_valid && !w_rxFull;
    assign w_rxPop   = w_ioRead && (w_ioReg == IO_RXDATA) && !w_rxEmpty;
    assign rx_ready  = !w_rxFull;

    opc5_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_txFifo (
        .clk     (clk),
        .reset_b (reset_b),
        .push    (w_txPush),
        .din     (dataout[7:0]),
        .pop     (w_txPop),
        .dout    (tx_data),
        .full    (w_txFull),
        .empty   (w_txEmpty)
    );

    opc5_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rxFifo (
        .clk     (clk),
        .reset_b (reset_b),
        .push    (w_rxPush),
        .din     (rx_data),
        .pop     (w_rxPop),
        .dout    (w_rxDout),
        .full    (w_rxFull),
        .empty   (w_rxEmpty)
    );

    always_ff @(posedge clk) begin
        if (!rnw && !w_isIo) r_ram[address[ADDR_W-1:0]] <= dataout;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_txOverflow <= 1'b0;
        end else if (w_ioWrite && (w_ioReg == IO_STATUS)) begin
            r_txOverflow <= 1'b0;
        end else if (w_txDrop) begin
            r_txOverflow <= 1'b1;
        end
    end

    // A write takes the place of this cycle's increment, so the cycle after the write reads 1.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_cycles <= 16'h0000;
        end else if (w_ioWrite && (w_ioReg == IO_CYCLES)) begin
            r_cycles <= 16'h0001;
        end else begin
            r_cycles <= r_cycles + 16'h0001;
        end
    end

    always_comb begin
        w_readData = r_ram[address[ADDR_W-1:0]];
        if (w_isIo) begin
            w_readData = 16'h0000;
            case (w_ioReg)
                IO_STATUS: begin
                    w_readData[ST_TXFULL] = w_txFull;
                    w_readData[ST_RXNE]   = !w_rxEmpty;
                    w_readData[ST_TXOVF]  = r_txOverflow;
                end
                IO_TXDATA: w_readData = 16'h0000;
                IO_RXDATA: w_readData = {8'h00, w_rxDout};
                IO_CYCLES: w_readData = r_cycles;
                default:   w_readData = 16'h0000;
            endcase
        end
    end

    assign datain = w_readData;

endmodule

// File: tb/tb_opc5_mem_responder.sv
// Scoreboard bench for opc5_mem_responder. Stimulus queues the expected read
// words and TX bytes, and a negedge monitor compares them with what the DUT presents.
module tb_opc5_mem_responder;

    localparam logic [15:0] A_STATUS = 16'hFFF0;
    localparam logic [15:0] A_TXDATA = 16'hFFF1;
    localparam logic [15:0] A_RXDATA = 16'hFFF2;
    localparam logic [15:0] A_CYCLES = 16'hFFF3;
    localparam logic [15:0] IDLE_ADDR = 16'h0100;

    logic        clk = 1'b0;
    logic        reset_b;
    logic [15:0] address;
    logic [15:0] dataout;
    logic        rnw;
    logic [15:0] datain;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    typedef struct {
        string       name;
        logic [15:0] value;
    } expect_t;

    expect_t    rdQ[$];
    logic [7:0] txQ[$];
    logic       rdStrobe = 1'b0;
    int         compared = 0;
    int         mismatched = 0;

    opc5_mem_responder #(.ADDR_W(10), .FIFO_DEPTH(4), .IO_BASE(16'hFFF0)) dut (
        .clk      (clk),
        .reset_b  (reset_b),
        .address  (address),
        .dataout  (dataout),
        .rnw      (rnw),
        .datain   (datain),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: compares the read data on strobed read cycles, and every emitted TX byte.
    always @(negedge clk) begin
        expect_t    e;
        logic [7:0] b;
        if (rdStrobe) begin
            compared++;
            if (rdQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL read-underflow: got %h expected none", datain);
            end else begin
                e = rdQ.pop_front();
                if (datain !== e.value) begin
                    mismatched++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, datain, e.value);
                end
            end
        end
        if (reset_b && tx_valid && tx_ready) begin
            compared++;
            if (txQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL tx-unexpected: got %h expected none", tx_data);
            end else begin
                b = txQ.pop_front();
                if (tx_data !== b) begin
                    mismatched++;
                    $display("[TB] FAIL tx-byte: got %h expected %h", tx_data, b);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            address = IDLE_ADDR;
            rnw = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic busWrite(input logic [15:0] addr, input logic [15:0] data);
        address = addr;
        dataout = data;
        rnw = 1'b0;
        @(posedge clk);
        #1;
        rnw = 1'b1;
        address = IDLE_ADDR;
    endtask

    task automatic busRead(input logic [15:0] addr, input logic [15:0] exp, input string name);
        expect_t e;
        e.name = name;
        e.value = exp;
        rdQ.push_back(e);
        address = addr;
        rnw = 1'b1;
        rdStrobe = 1'b1;
        @(posedge clk);
        #1;
        rdStrobe = 1'b0;
        address = IDLE_ADDR;
    endtask

    task automatic rxPush(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic applyStimulus();
        // Reset state, checked while reset is still asserted.
        reset_b = 1'b0;
        address = A_STATUS;
        dataout = 16'h0000;
        rnw = 1'b1;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        #3;
        checkOutput("rst-tx_valid", {15'd0, tx_valid}, 16'h0000);
        checkOutput("rst-rx_ready", {15'd0, rx_ready}, 16'h0001);
        checkOutput("rst-tx_data", {8'd0, tx_data}, 16'h0000);
        checkOutput("rst-status", datain, 16'h0000);
        address = A_CYCLES;
        #1;
        checkOutput("rst-cycles", datain, 16'h0000);
        @(posedge clk);
        #1;
        reset_b = 1'b1;
        address = IDLE_ADDR;

        // RAM and the aliasing of addresses modulo 2^ADDR_W.
        busWrite(16'h0000, 16'h1234);
        busRead(16'h0000, 16'h1234, "ram-0000");
        busWrite(16'h0405, 16'hBEEF);
        busRead(16'h0005, 16'hBEEF, "ram-alias");
        busRead(16'h0405, 16'hBEEF, "ram-direct");
        busRead(A_TXDATA, 16'h0000, "txdata-read");

        // TX overflow with the sink stalled, then drain.
        for (int i = 1; i <= 5; i++) busWrite(A_TXDATA, 16'(i));
        busRead(A_STATUS, 16'h0005, "status-full-ovf");
        for (int i = 1; i <= 4; i++) txQ.push_back(8'(i));
        tx_ready = 1'b1;
        idle(4);
        checkOutput("tx-drained", {15'd0, tx_valid}, 16'h0000);
        tx_ready = 1'b0;
        busRead(A_STATUS, 16'h0004, "status-ovf-sticky");
        busWrite(A_STATUS, 16'h0000);
        busRead(A_STATUS, 16'h0000, "status-cleared");

        // Full TX FIFO: a push that coincides with a pop is accepted.
        for (int i = 0; i < 4; i++) busWrite(A_TXDATA, 16'h0011 + 16'(i));
        busRead(A_STATUS, 16'h0001, "status-full");
        for (int i = 0; i < 5; i++) txQ.push_back(8'h11 + 8'(i));
        tx_ready = 1'b1;
        busWrite(A_TXDATA, 16'h0015);
        idle(4);
        checkOutput("tx-drained2", {15'd0, tx_valid}, 16'h0000);
        tx_ready = 1'b0;
        busRead(A_STATUS, 16'h0000, "status-no-ovf");

        // RX path.
        rxPush(8'hA5);
        rxPush(8'h3C);
        busRead(A_STATUS, 16'h0002, "status-rxne");
        busRead(A_RXDATA, 16'h00A5, "rx-pop1");
        busRead(A_RXDATA, 16'h003C, "rx-pop2");
        busRead(A_STATUS, 16'h0000, "status-rx-empty");
        busRead(A_RXDATA, 16'h0000, "rx-pop-empty");
        rxPush(8'h77);
        rx_valid = 1'b1;
        rx_data = 8'h88;
        busRead(A_RXDATA, 16'h0077, "rx-pushpop");
        rx_valid = 1'b0;
        busRead(A_STATUS, 16'h0002, "status-rx-kept");
        busRead(A_RXDATA, 16'h0088, "rx-pop-88");
        busRead(A_STATUS, 16'h0000, "status-rx-empty2");
        busWrite(A_RXDATA, 16'h0055);
        busRead(A_STATUS, 16'h0000, "rxdata-write-ignored");

        // RX full: rx_ready drops.
        for (int i = 1; i <= 4; i++) rxPush(8'(i));
        checkOutput("rx-full-ready", {15'd0, rx_ready}, 16'h0000);
        for (int i = 1; i <= 4; i++) busRead(A_RXDATA, 16'(i), "rx-drain");
        checkOutput("rx-ready-again", {15'd0, rx_ready}, 16'h0001);

        // Cycle counter: a write gives 1 on the next cycle, then wrap.
        busWrite(A_CYCLES, 16'h0000);
        busRead(A_CYCLES, 16'h0001, "cycles-after-write");
        busWrite(A_CYCLES, 16'h0000);
        idle(9);
        busRead(A_CYCLES, 16'h000A, "cycles-10");
        idle(16'hFFFF - 11);
        busRead(A_CYCLES, 16'hFFFF, "cycles-ffff");
        busRead(A_CYCLES, 16'h0000, "cycles-wrap");

        idle(2);
        checkOutput("rdq-drained", 16'(rdQ.size()), 16'h0000);
        checkOutput("txq-drained", 16'(txQ.size()), 16'h0000);
    endtask

    initial begin
        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/opc5_mem_responder.md
# opc5_mem_responder

Memory-side responder for the OPC5 CPU bus: it supplies the instruction/data word the CPU samples each cycle and commits CPU stores. It combines a word-addressed RAM with a small memory-mapped I/O window. The window holds a byte transmit FIFO, a byte receive FIFO and a free-running cycle counter. It sits directly between the CPU's `address`/`dataout`/`rnw` pins and the board-level serial byte streams.

## Interface
- `ADDR_W`, default 10: RAM is 2^ADDR_W 16-bit words, indexed by `address[ADDR_W-1:0]`.
- `FIFO_DEPTH`, default 4: entries per byte FIFO; must be a power of two, ≥2.
- `IO_BASE`, default 16'hFFF0: base of the 4-word I/O window, which occupies IO_BASE..IO_BASE+3.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_b` in 1: asynchronous, active-low reset.
- `address` in 16: CPU bus address.
- `dataout` in 16: CPU write data.
- `rnw` in 1: 1 = read, 0 = write.
- `datain` out 16: read data to the CPU, combinational from `address`.
- `tx_data` out 8: head byte of the TX FIFO.
- `tx_valid` out 1: TX FIFO non-empty.
- `tx_ready` in 1: sink accepts `tx_data` when `tx_valid & tx_ready`.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: incoming byte present.
- `rx_ready` out 1: RX FIFO not full.

## Operation
- **Address decode.**
  - `address` in IO_BASE..IO_BASE+3 selects I/O.
  - Any other address selects RAM, aliased modulo 2^ADDR_W.
- **RAM.**
  - Asynchronous read.
  - Synchronous write at the rising edge when `rnw==0`.
  - No reset; contents are undefined after power-up.
- **I/O offset 0, STATUS.**
  - Read returns bit0 tx_full, bit1 rx_nonempty, bit2 tx_overflow (sticky). All other bits read 0.
  - Any write clears tx_overflow.
- **I/O offset 1, TXDATA.**
  - A write pushes `dataout[7:0]`.
  - If the FIFO is full and no TX pop occurs in the same cycle, the byte is dropped and tx_overflow is set.
  - Read returns 16'h0000.
- **I/O offset 2, RXDATA.**
  - A read returns {8'h00, RX head} and pops the head at the rising edge.
  - A read on an empty FIFO returns 16'h0000 and changes no state.
  - Writes are ignored.
  - A pop happens on every `rnw==1` cycle addressing RXDATA, including instruction fetches.
- **I/O offset 3, CYCLES.**
  - Read returns a free-running 16-bit counter that increments every cycle and wraps FFFF→0000.
  - A write loads 0; the next cycle reads 0001.
- **TX FIFO.**
  - Pops when `tx_valid & tx_ready`.
  - `tx_data` is stable while `tx_valid` is high and not popped.
- **RX FIFO.**
  - Pushes `rx_data` when `rx_valid & rx_ready`.
  - A push and a CPU pop in the same cycle are both honoured.

## Timing
- **Reset (async assert).** Both FIFOs empty, tx_overflow=0, counter=0. Outputs: `tx_valid`=0, `rx_ready`=1, `tx_data`=8'h00. `datain` follows `address` combinationally (RAM value, or I/O value from reset state).
- **Read latency 0.** `datain` is valid in the same cycle `address` is presented, because the CPU samples it at the next rising edge.
- **Write effect.** Visible to a read in the cycle after the write cycle.
- **Status timing.** All status and FIFO flags reflect state at the start of the cycle. A push accepted in cycle N sets `tx_valid`/rx_nonempty from cycle N+1.
- **Full TX FIFO.** A CPU push is accepted in a cycle where a TX pop also occurs; occupancy is unchanged.
- **Full RX FIFO.** `rx_ready`=0; a byte offered on `rx_valid` is held by the source, not lost.
- **Pointers.** log2(FIFO_DEPTH)+1 bits, wrapping. Full is when the pointers differ only in the MSB.
- **Reset mid-transfer.** FIFO contents are discarded immediately. RAM is unaffected except that a write edge coinciding with reset assertion is not guaranteed.

## Structure
- **Package `opc5_mem_pkg`:**
  - I/O offsets IO_STATUS=0, IO_TXDATA=1, IO_RXDATA=2, IO_CYCLES=3.
  - Status bit positions ST_TXFULL=0, ST_RXNE=1, ST_TXOVF=2.
- **Sub-module `opc5_byte_fifo`:** parameter DEPTH; ports push/din/pop/dout/full/empty. It is instantiated twice (TX and RX) and has the same clock and reset as the parent.
- **Top level:** decode, read mux, RAM array, counter and overflow flag.

## Test plan
- Reset, then read address 16'h0000 with RAM preloaded with 16'h1234 → `datain`=1234 in the same cycle; `tx_valid`=0, `rx_ready`=1.
- Write 16'hBEEF to address 16'h0405 with ADDR_W=10, then read 16'h0005 next cycle → 16'hBEEF (alias).
- Hold `tx_ready`=0, write TXDATA 5 times with bytes 01..05 → STATUS reads 16'h0005 (full + overflow). Raise `tx_ready` → bytes 01,02,03,04 emitted, one per cycle. Write STATUS → 16'h0000.
- With `tx_ready`=1 held and the FIFO full, a CPU write coinciding with a pop is accepted → bytes emitted in order, no overflow.
- Push RX bytes A5,3C; read RXDATA three times → 00A5, 003C, 0000. STATUS bit1 clears after the second pop; a same-cycle push+pop keeps occupancy.
- Write CYCLES, then read it 10 cycles later → 16'h000A. Preload the counter at FFFF → next read 0000.
